// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port fixed-latency memory between the instruction refill
// path (read-only) and the data load/store path, returning read data with an ack pulse.
module mem_port_arbiter #(
    parameter int dataW      = 32,
    parameter int MemLatency = 1,
    parameter int StarvLimit = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             InsReq,
    input  logic [dataW-1:0] InsAddr,
    output logic             InsAck,
    input  logic             DataReq,
    input  logic             DataWe,
    input  logic [dataW-1:0] DataAddr,
    input  logic [dataW-1:0] DataWrData,
    output logic             DataAck,
    output logic [dataW-1:0] RdData,
    output logic [dataW-1:0] MemAddr,
    output logic [dataW-1:0] MemWrData,
    output logic             MemRdEn,
    output logic             MemWrEn,
    input  logic [dataW-1:0] MemRdData,
    output logic             ArbBusy
);

    // state | meaning
    // IDLE  | sample requests, pick a winner and latch its transaction
    // ISSUE | drive one memory enable cycle
    // WAIT  | count down memory read latency, capture read data at zero
    // DONE  | pulse the owner's acknowledge
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int                StarvW   = $clog2(StarvLimit + 1);
    localparam logic [StarvW-1:0] StarvMax = StarvW'(StarvLimit);
    localparam logic [3:0]        LatLoad  = 4'(MemLatency - 1);

    state_t            state;
    state_t            state_nxt;
    logic              owner_ins;
    logic              wr_flag;
    logic [3:0]        lat_cnt;
    logic [StarvW-1:0] starv_cnt;
    logic              grant_ins;
    logic              grant_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // Data wins contention until the instruction side has waited StarvLimit grants.
        grant_ins  = InsReq && (!DataReq || (starv_cnt == StarvMax));
        grant_data = DataReq && !grant_ins;
        state_nxt  = state;
        MemRdEn    = 1'b0;
        MemWrEn    = 1'b0;
        InsAck     = 1'b0;
        DataAck    = 1'b0;
        ArbBusy    = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_ins || grant_data) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                MemRdEn   = !wr_flag;
                MemWrEn   = wr_flag;
                state_nxt = wr_flag ? DONE : WAIT;
            end
            WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                InsAck    = owner_ins;
                DataAck   = !owner_ins;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_ins <= 1'b0;
            wr_flag   <= 1'b0;
            lat_cnt   <= 4'd0;
            starv_cnt <= '0;
            MemAddr   <= '0;
            MemWrData <= '0;
            RdData    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ins) begin
                        owner_ins <= 1'b1;
                        wr_flag   <= 1'b0;
                        MemAddr   <= InsAddr;
                        starv_cnt <= '0;
                    end else if (grant_data) begin
                        owner_ins <= 1'b0;
                        wr_flag   <= DataWe;
                        MemAddr   <= DataAddr;
                        MemWrData <= DataWrData;
                        if (InsReq && (starv_cnt != StarvMax)) begin
                            starv_cnt <= starv_cnt + StarvW'(1);
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= LatLoad;
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        RdData <= MemRdData;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grant order,
// enable/ack cycles and returned data; a behavioural memory sits on the memory port.
module tb_mem_port_arbiter;

    localparam int LAT   = 3;
    localparam int LIMIT = 4;
    localparam int NCYC  = 3000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        InsReq = 1'b0;
    logic [31:0] InsAddr = '0;
    logic        InsAck;
    logic        DataReq = 1'b0;
    logic        DataWe = 1'b0;
    logic [31:0] DataAddr = '0;
    logic [31:0] DataWrData = '0;
    logic        DataAck;
    logic [31:0] RdData;
    logic [31:0] MemAddr;
    logic [31:0] MemWrData;
    logic        MemRdEn;
    logic        MemWrEn;
    logic [31:0] MemRdData;
    logic        ArbBusy;

    mem_port_arbiter #(.dataW(32), .MemLatency(LAT), .StarvLimit(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .InsReq(InsReq), .InsAddr(InsAddr), .InsAck(InsAck),
        .DataReq(DataReq), .DataWe(DataWe), .DataAddr(DataAddr), .DataWrData(DataWrData),
        .DataAck(DataAck), .RdData(RdData),
        .MemAddr(MemAddr), .MemWrData(MemWrData), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
        .MemRdData(MemRdData), .ArbBusy(ArbBusy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        return 32'h9E37_79B9 * 32'(a + 1);
    endfunction

    // Behavioural memory: write in the enable cycle, read data valid LAT cycles later.
    logic [31:0] mem [16];
    logic        written [16];
    logic [31:0] rd_pipe [LAT];

    always @(posedge clock) begin
        if (MemWrEn) begin
            mem[MemAddr[3:0]]     <= MemWrData;
            written[MemAddr[3:0]] <= 1'b1;
        end
        if (MemRdEn) begin
            rd_pipe[0] <= (written[MemAddr[3:0]] === 1'b1) ? mem[MemAddr[3:0]]
                                                            : init_word(int'(MemAddr[3:0]));
        end else begin
            rd_pipe[0] <= 32'hBAD0_BAD0;
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign MemRdData = rd_pipe[LAT-1];

    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd;
    logic [31:0] t_addr;
    logic [31:0] t_data;
    bit          t_valid;
    bit          t_ins;
    bit          t_we;
    int          t_s;
    int          t_a;
    int          free_cyc;
    int          starv;
    int          rst_cnt;
    int          quiet;
    bit          rst_done;
    bit          ins_done_now;
    bit          data_done_now;
    bit          gi;

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        exp_rd   = '0;
        t_valid  = 1'b0;
        t_ins    = 1'b0;
        t_we     = 1'b0;
        t_addr   = '0;
        t_data   = '0;
        t_s      = 0;
        t_a      = 0;
        free_cyc = 0;
        starv    = 0;
        rst_cnt  = 3;
        quiet    = 0;
        rst_done = 1'b0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clock);
            ins_done_now  = 1'b0;
            data_done_now = 1'b0;
            if (rst_cnt > 0) begin
                check_eq("rst_busy",   32'(ArbBusy), 32'd0);
                check_eq("rst_rden",   32'(MemRdEn), 32'd0);
                check_eq("rst_wren",   32'(MemWrEn), 32'd0);
                check_eq("rst_insack", 32'(InsAck),  32'd0);
                check_eq("rst_dack",   32'(DataAck), 32'd0);
                check_eq("rst_rddata", RdData,       32'd0);
                check_eq("rst_maddr",  MemAddr,      32'd0);
                check_eq("rst_mwdata", MemWrData,    32'd0);
                rst_cnt--;
                if (rst_cnt != 0) continue;
                reset    = 1'b0;
                quiet    = 3;
                free_cyc = cyc;
            end else begin
                if (t_valid && (cyc == t_a) && !t_we) exp_rd = ref_mem[t_addr[3:0]];
                check_eq("busy",    32'(ArbBusy), 32'(t_valid && (cyc > t_s) && (cyc <= t_a)));
                check_eq("rden",    32'(MemRdEn), 32'(t_valid && (cyc == t_s + 1) && !t_we));
                check_eq("wren",    32'(MemWrEn), 32'(t_valid && (cyc == t_s + 1) && t_we));
                check_eq("ins_ack", 32'(InsAck),  32'(t_valid && (cyc == t_a) && t_ins));
                check_eq("data_ack", 32'(DataAck), 32'(t_valid && (cyc == t_a) && !t_ins));
                check_eq("rd_data", RdData, exp_rd);
                if (t_valid && (cyc == t_s + 1)) begin
                    check_eq("mem_addr", MemAddr, t_addr);
                    if (t_we) check_eq("mem_wrdata", MemWrData, t_data);
                end

                // One reset pulse in the second WAIT cycle of a read.
                if (!rst_done && (cyc > 400) && t_valid && !t_we && (cyc == t_s + 3)) begin
                    reset    = 1'b1;
                    rst_cnt  = 2;
                    rst_done = 1'b1;
                    t_valid  = 1'b0;
                    starv    = 0;
                    exp_rd   = '0;
                    InsReq   = 1'b0;
                    DataReq  = 1'b0;
                    continue;
                end

                if (t_valid && (cyc == t_a)) begin
                    if (t_ins) begin
                        InsReq       = 1'b0;
                        ins_done_now = 1'b1;
                    end else begin
                        DataReq       = 1'b0;
                        data_done_now = 1'b1;
                    end
                    t_valid  = 1'b0;
                    free_cyc = cyc + 1;
                end
            end

            if (quiet > 0) begin
                quiet--;
            end else begin
                if (!InsReq) begin
                    InsAddr = $urandom;
                    if (!ins_done_now && ($urandom_range(0, 99) < 40)) InsReq = 1'b1;
                end
                if (!DataReq) begin
                    DataAddr   = $urandom;
                    DataWrData = $urandom;
                    DataWe     = ($urandom_range(0, 1) == 1);
                    if (!data_done_now && ($urandom_range(0, 99) < 80)) DataReq = 1'b1;
                end
            end

            if (!t_valid && (cyc >= free_cyc) && (InsReq || DataReq)) begin
                gi      = InsReq && (!DataReq || (starv == LIMIT));
                t_valid = 1'b1;
                t_ins   = gi;
                t_we    = !gi && DataWe;
                t_addr  = gi ? InsAddr : DataAddr;
                t_data  = DataWrData;
                t_s     = cyc;
                t_a     = cyc + (t_we ? 2 : 2 + LAT);
                if (gi) starv = 0;
                else if (InsReq && (starv < LIMIT)) starv++;
                if (t_we) ref_mem[t_addr[3:0]] = t_data;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the instruction cache refill path (read-only) and the data load/store path. The block arbitrates, sequences each access through a fixed-latency memory, and returns read data with a one-cycle acknowledge pulse. It sits between the instruction cache read-address/read-data port, the data-access unit, and the program/data memory.

Parameters:
dataW, 32, width of addresses and data words
MemLatency, 1, cycles from the memory enable cycle to valid MemRdData (1..15)
StarvLimit, 4, consecutive data grants allowed while InsReq is pending before instruction gets priority (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
InsReq  in  1  instruction refill read request, level, held until InsAck
InsAddr  in  dataW  instruction read address, stable while InsReq high
InsAck  out  1  one-cycle pulse, RdData holds instruction word
DataReq  in  1  data access request, level, held until DataAck
DataWe  in  1  1 = write, 0 = read; stable while DataReq high
DataAddr  in  dataW  data address
DataWrData  in  dataW  write data
DataAck  out  1  one-cycle pulse; for reads RdData valid
RdData  out  dataW  registered read data, valid in the Ack cycle, held until next read capture
MemAddr  out  dataW  memory address, registered
MemWrData  out  dataW  memory write data, registered
MemRdEn  out  1  memory read enable, high exactly one cycle per read
MemWrEn  out  1  memory write enable, high exactly one cycle per write
MemRdData  in  dataW  memory read data, valid MemLatency cycles after the MemRdEn cycle
ArbBusy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state IDLE; InsAck, DataAck, MemRdEn, MemWrEn, ArbBusy = 0; RdData, MemAddr, MemWrData = 0; latency counter and starvation counter = 0. In-flight transaction discarded, no Ack issued; requesters reissue.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: samples InsReq/DataReq at the clock edge. If neither, stay. Otherwise select a winner; latch owner, address, write data, and write flag (instruction always read); go to ISSUE.
- Arbitration: DataReq alone -> data; InsReq alone -> instruction; both -> data unless starvation counter == StarvLimit, then instruction.
- Starvation counter: +1 on each data grant made while InsReq high (saturates at StarvLimit); cleared on every instruction grant; unchanged otherwise.
- ISSUE (1 cycle): MemAddr/MemWrData driven from latched values; MemRdEn=1 for read, MemWrEn=1 for write, never both. Write -> DONE. Read -> WAIT with counter loaded MemLatency-1.
- WAIT: if counter==0, capture MemRdData into RdData and go DONE; else decrement and stay. Read occupies MemLatency WAIT cycles.
- DONE (1 cycle): assert the owner's Ack (InsAck or DataAck, never both); go IDLE. Write Ack leaves RdData unchanged.
- Latency from request sampled in IDLE (cycle 0): write Ack in cycle 2; read Ack in cycle 2+MemLatency.
- Requester deasserts Req at the edge ending its Ack cycle. A Req still high in the following IDLE cycle is a new transaction.
- Requests arriving while not IDLE are ignored until IDLE. Address/data changes on the losing requester do not affect the active transaction.
- Minimum turnaround: one IDLE cycle between consecutive transactions.
- ArbBusy = (state != IDLE).

Test Plan:
1. Assert reset mid-run -> all outputs 0, ArbBusy 0; release with no requests -> stays IDLE, no enables.
2. InsReq=1, InsAddr=0x10, memory returns 0xDEADBEEF, MemLatency=1 -> MemRdEn=1 with MemAddr=0x10 for exactly cycle 1; InsAck pulse in cycle 3 with RdData=0xDEADBEEF; DataAck stays 0.
3. DataReq=1, DataWe=1, DataAddr=0x20, DataWrData=0x45 -> MemWrEn=1 with MemAddr=0x20, MemWrData=0x45 in cycle 1 only; DataAck in cycle 2; MemRdEn never high; RdData unchanged.
4. InsReq and DataReq (read, addr 0x40) rise together -> data served first (DataAck cycle 3); instruction issued from the next IDLE, InsAck 4 cycles later.
5. InsReq held at 0x0, DataReq re-asserted continuously -> data granted 4 times, 5th grant instruction (MemAddr=0x0), counter cleared, next contention goes to data.
6. MemLatency=3, read issued, reset pulsed in 2nd WAIT cycle -> no Ack, outputs 0; new InsReq after reset -> InsAck 5 cycles after sampling with correct data.
